// File: rtl/clk_cfg_pkg.sv
// rtl/clk_cfg_pkg.sv - shared encodings and helpers for the clock configuration sequencer
package clk_cfg_pkg;

    typedef enum logic [1:0] {
        SRC_ROSC = 2'b00,
        SRC_PLL  = 2'b01,
        SRC_8MHZ = 2'b10,
        SRC_INV  = 2'b11
    } clk_src_e;

    typedef enum logic [1:0] {
        DIV_1 = 2'b00,
        DIV_2 = 2'b01,
        DIV_4 = 2'b10,
        DIV_8 = 2'b11
    } clk_div_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PARK   = 3'd1,
        PLL_ON = 3'd2,
        SEL    = 3'd3,
        UNPARK = 3'd4,
        DIV    = 3'd5,
        DONE   = 3'd6
    } seq_state_e;

    typedef struct packed {
        logic [1:0] src;
        logic [1:0] trim;
        logic [1:0] rosc;
        logic [1:0] div;
    } cfg_req_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_cfg_seq_if.sv
// rtl/clk_cfg_seq_if.sv - request handshake and status bundle between software and the sequencer
interface clk_cfg_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_src;
    logic [1:0] req_trim;
    logic [1:0] req_rosc;
    logic [1:0] req_div;
    logic       done;
    logic       cfg_err;

    modport master (
        output req_valid, req_src, req_trim, req_rosc, req_div,
        input  req_ready, done, cfg_err
    );

    modport slave (
        input  req_valid, req_src, req_trim, req_rosc, req_div,
        output req_ready, done, cfg_err
    );
endinterface

// File: rtl/clk_cfg_seq_timer.sv
// rtl/clk_cfg_seq_timer.sv - loadable down-counter timing each sequencer state
module seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);
    logic [W-1:0] count;

    // Loaded with N on state entry; expire in the N-th cycle so the state lasts exactly N cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == W'(1));
endmodule

// File: rtl/clk_cfg_seq.sv
// rtl/clk_cfg_seq.sv - glitch-safe clock select sequencer; CLK_CFG_SEQ_PLL_AUTO_OFF_EN drops pll_en when unparking to a non-PLL source
module clk_cfg_seq
    import clk_cfg_pkg::*;
#(
    parameter int LOCK_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    clk_cfg_seq_if.slave       bus,
    output logic               pll_en,
    output logic [1:0]         pll_trim,
    output logic               sel_8mhz,
    output logic               sel_pll,
    output logic [1:0]         sel_rosc,
    output logic [1:0]         clk_div
);
    localparam int TW = $clog2(max_int(LOCK_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [TW-1:0] LOCK_VAL   = TW'(LOCK_CYCLES);
    localparam logic [TW-1:0] SETTLE_VAL = TW'(SETTLE_CYCLES);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_PARK   = PARK;
    localparam logic [2:0] ST_PLL_ON = PLL_ON;
    localparam logic [2:0] ST_SEL    = SEL;
    localparam logic [2:0] ST_UNPARK = UNPARK;
    localparam logic [2:0] ST_DIV    = DIV;
    localparam logic [2:0] ST_DONE   = DONE;

    logic [2:0]    state;
    logic [2:0]    next_state;
    cfg_req_t      tgt;
    logic          cfg_err_q;
    logic          accept;
    logic          need_pll;
    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_expire;

    assign accept   = (state == ST_IDLE) && bus.req_valid;
    // The PLL is only (re)locked when it is off or its trim has to change.
    assign need_pll = (tgt.src == SRC_PLL) && (!pll_en || (pll_trim != tgt.trim));

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept && (bus.req_src != SRC_INV)) next_state = ST_PARK;
            ST_PARK:   if (tmr_expire) next_state = need_pll ? ST_PLL_ON : ST_SEL;
            ST_PLL_ON: if (tmr_expire) next_state = ST_SEL;
            ST_SEL:    if (tmr_expire) next_state = ST_UNPARK;
            ST_UNPARK: if (tmr_expire) next_state = ST_DIV;
            ST_DIV:    if (tmr_expire) next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = SETTLE_VAL;
        if (next_state != state) begin
            tmr_load  = (next_state != ST_IDLE) && (next_state != ST_DONE);
            tmr_value = (next_state == ST_PLL_ON) ? LOCK_VAL : SETTLE_VAL;
        end
    end

    seq_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .value  (tmr_value),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tgt       <= '0;
            cfg_err_q <= 1'b0;
            pll_en    <= 1'b0;
            pll_trim  <= 2'b00;
            sel_8mhz  <= 1'b1;
            sel_pll   <= 1'b0;
            sel_rosc  <= 2'b00;
            clk_div   <= DIV_1;
        end else begin
            state     <= next_state;
            cfg_err_q <= accept && (bus.req_src == SRC_INV);
            if (accept) begin
                tgt <= '{src: bus.req_src, trim: bus.req_trim, rosc: bus.req_rosc, div: bus.req_div};
            end
            // Each control moves on the edge that enters its state and then holds.
            if (next_state != state) begin
                case (next_state)
                    ST_PARK: sel_8mhz <= 1'b1;
                    ST_PLL_ON: begin
                        pll_en   <= 1'b1;
                        pll_trim <= tgt.trim;
                    end
                    ST_SEL: begin
                        sel_pll  <= (tgt.src == SRC_PLL);
                        sel_rosc <= tgt.rosc;
                    end
                    ST_UNPARK: begin
                        sel_8mhz <= (tgt.src == SRC_8MHZ);
`ifdef CLK_CFG_SEQ_PLL_AUTO_OFF_EN
                        if (tgt.src != SRC_PLL) pll_en <= 1'b0;
`else
                        pll_en <= pll_en;
`endif
                    end
                    ST_DIV: clk_div <= tgt.div;
                    default: ;
                endcase
            end
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_clk_cfg_seq.sv
// tb/tb_clk_cfg_seq.sv - directed vector bench for clk_cfg_seq with S=4, L=16
module tb_clk_cfg_seq;
`ifdef CLK_CFG_SEQ_PLL_AUTO_OFF_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam bit EN_AFTER_OFF = AUTO ? 1'b0 : 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_en, sel_8mhz, sel_pll;
    logic [1:0] pll_trim, sel_rosc, clk_div;
    int         n_vec = 0;
    int         n_err = 0;

    clk_cfg_seq_if bus ();

    clk_cfg_seq #(.LOCK_CYCLES(16), .SETTLE_CYCLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .pll_en   (pll_en),
        .pll_trim (pll_trim),
        .sel_8mhz (sel_8mhz),
        .sel_pll  (sel_pll),
        .sel_rosc (sel_rosc),
        .clk_div  (clk_div)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] src, trim, rosc, div;
        int         exp_done;
        int         exp_err;
        int         exp_off;
        logic [8:0] exp_out;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {pll_en, pll_trim, sel_8mhz, sel_pll, sel_rosc, clk_div};
    endfunction

    task automatic drive(input logic v, input logic [1:0] s, t, r, d);
        bus.req_valid = v;
        bus.req_src   = s;
        bus.req_trim  = t;
        bus.req_rosc  = r;
        bus.req_div   = d;
    endtask

    task automatic run_req(input logic [1:0] s, t, r, d, input int budget,
                           output int done_c, output int err_c, output int off_c, output int rdy_lo);
        logic prev_en;
        done_c = 0; err_c = 0; off_c = 0; rdy_lo = 0;
        @(negedge clk);
        drive(1'b1, s, t, r, d);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        prev_en = pll_en;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (bus.cfg_err && err_c == 0) err_c = c;
            if (prev_en && !pll_en && off_c == 0) off_c = c;
            if (!bus.req_ready) rdy_lo++;
            prev_en = pll_en;
            if (bus.done) begin
                done_c = c;
                break;
            end
        end
    endtask

    initial begin
        int dc, ec, oc, rl;
        int e_s8, e_en, e_sp, e_div, e_done, e_rdy;

        tbl[0] = '{2'b01, 2'b10, 2'b00, 2'b01, 17, 0, 0, {1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 2'b01}};
        tbl[1] = '{2'b01, 2'b11, 2'b00, 2'b01, 33, 0, 0, {1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 2'b01}};
        tbl[2] = '{2'b10, 2'b00, 2'b01, 2'b10, 17, 0, AUTO ? 9 : 0,
                   {EN_AFTER_OFF, 2'b11, 1'b1, 1'b0, 2'b01, 2'b10}};
        tbl[3] = '{2'b11, 2'b01, 2'b11, 2'b11, 0, 1, 0,
                   {EN_AFTER_OFF, 2'b11, 1'b1, 1'b0, 2'b01, 2'b10}};
        tbl[4] = '{2'b00, 2'b01, 2'b10, 2'b11, 17, 0, 0,
                   {EN_AFTER_OFF, 2'b11, 1'b0, 1'b0, 2'b10, 2'b11}};
        tbl[5] = '{2'b01, 2'b11, 2'b11, 2'b00, AUTO ? 33 : 17, 0, 0,
                   {1'b1, 2'b11, 1'b0, 1'b1, 2'b11, 2'b00}};

        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (3) @(negedge clk);
        chk("reset_outputs", {23'd0, outs()}, {23'd0, 9'b0_00_1_0_00_00});
        chk("reset_status", {29'd0, bus.req_ready, bus.done, bus.cfg_err}, 32'b100);
        rst_n = 1'b1;

        // First PLL request from reset, checked cycle by cycle.
        e_s8 = 0; e_en = 0; e_sp = 0; e_div = 0; e_done = 0; e_rdy = 0;
        @(negedge clk);
        drive(1'b1, 2'b01, 2'b10, 2'b00, 2'b01);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (sel_8mhz !== (c <= 24)) e_s8++;
            if (pll_en !== (c >= 5)) e_en++;
            if (pll_trim !== ((c >= 5) ? 2'b10 : 2'b00)) e_en++;
            if (sel_pll !== (c >= 21)) e_sp++;
            if (clk_div !== ((c >= 29) ? 2'b01 : 2'b00)) e_div++;
            if (bus.done !== (c == 33)) e_done++;
            if (bus.req_ready !== (c >= 34)) e_rdy++;
        end
        chk("pll_seq_sel_8mhz", e_s8, 0);
        chk("pll_seq_pll_en_trim", e_en, 0);
        chk("pll_seq_sel_pll", e_sp, 0);
        chk("pll_seq_clk_div", e_div, 0);
        chk("pll_seq_done", e_done, 0);
        chk("pll_seq_ready", e_rdy, 0);

        for (int i = 0; i < 6; i++) begin
            run_req(tbl[i].src, tbl[i].trim, tbl[i].rosc, tbl[i].div,
                    (tbl[i].exp_done == 0) ? 40 : tbl[i].exp_done + 5, dc, ec, oc, rl);
            chk($sformatf("vec%0d_done_cycle", i), dc, tbl[i].exp_done);
            chk($sformatf("vec%0d_cfg_err_cycle", i), ec, tbl[i].exp_err);
            chk($sformatf("vec%0d_pll_off_cycle", i), oc, tbl[i].exp_off);
            chk($sformatf("vec%0d_outputs", i), {23'd0, outs()}, {23'd0, tbl[i].exp_out});
            if (tbl[i].exp_done == 0) chk($sformatf("vec%0d_ready_low", i), rl, 0);
        end

        // Busy: a different request held valid is ignored until the sequencer returns to IDLE.
        rl = 0; dc = 0;
        @(negedge clk);
        drive(1'b1, 2'b10, 2'b00, 2'b00, 2'b10);
        @(posedge clk);
        #1 drive(1'b1, 2'b00, 2'b00, 2'b01, 2'b01);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!bus.req_ready) rl++;
            if (bus.done) begin
                dc = c;
                break;
            end
        end
        chk("busy_first_done", dc, 17);
        chk("busy_ready_low_cycles", rl, 17);
        chk("busy_first_div", clk_div, 2'b10);
        @(negedge clk);
        chk("busy_ready_after_done", bus.req_ready, 1'b1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        dc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done) begin
                dc = c;
                break;
            end
        end
        chk("busy_second_done", dc, 17);
        chk("busy_second_outputs", {23'd0, outs()},
            {23'd0, EN_AFTER_OFF, 2'b11, 1'b0, 1'b0, 2'b01, 2'b01});

        // Reset asserted in the middle of PLL_ON.
        @(negedge clk);
        drive(1'b1, 2'b01, 2'b01, 2'b00, 2'b11);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("midlock_pll_en", {pll_en, pll_trim}, 3'b101);
        #2 rst_n = 1'b0;
        #1;
        chk("midlock_reset_outputs", {23'd0, outs()}, {23'd0, 9'b0_00_1_0_00_00});
        chk("midlock_reset_status", {29'd0, bus.req_ready, bus.done, bus.cfg_err}, 32'b100);
        @(negedge clk);
        rst_n = 1'b1;
        e_done = 0; e_rdy = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.done) e_done++;
            if (!bus.req_ready) e_rdy++;
        end
        chk("post_reset_idle", {e_done[15:0], e_rdy[15:0]}, 32'd0);
        chk("post_reset_outputs", {23'd0, outs()}, {23'd0, 9'b0_00_1_0_00_00});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
